// File: rtl/lsu_arb.sv
// Load/store arbiter sharing one memory port between the two requesters.
// One transaction in flight; loads squashable by pipeline flush.
module lsu_arb #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            exu_ren,
  input  logic [XLEN-1:0] exu_raddr,
  input  logic [4:0]      exu_ralu,
  input  logic            exu_wen,
  input  logic [XLEN-1:0] exu_waddr,
  input  logic [4:0]      exu_walu,
  input  logic [XLEN-1:0] exu_wdata,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_exu_rvalid,
  output logic            lsu_exu_wready,
  output logic            mem_valid,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [4:0]      mem_alu,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    LD_DRAIN,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t state, state_nx;
  logic   rr_ld;
  logic   hazard, ld_ok;
  logic   gnt_ld, gnt_st;
  logic   rv_nx, wr_nx;

  assign mem_valid = (state == LD_REQ) | (state == ST_REQ);

  always_comb begin
    hazard   = exu_wen &
               (exu_raddr[XLEN-1:2] == exu_waddr[XLEN-1:2]);
    ld_ok    = exu_ren & ~flush_pipeline & ~hazard;
    gnt_st   = 1'b0;
    gnt_ld   = 1'b0;
    rv_nx    = 1'b0;
    wr_nx    = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        gnt_st = exu_wen & (~ld_ok | ~rr_ld);
        gnt_ld = ld_ok & (~exu_wen | rr_ld);
        if (gnt_st) begin
          state_nx = ST_REQ;
        end else if (gnt_ld) begin
          state_nx = LD_REQ;
        end
      end
      LD_REQ: begin
        if (flush_pipeline) begin
          state_nx = IDLE;
        end else if (mem_ready) begin
          state_nx = LD_WAIT;
        end
      end
      LD_WAIT: begin
        // a flush landing with the response squashes it in place
        if (mem_resp_valid) begin
          state_nx = IDLE;
          rv_nx    = ~flush_pipeline;
        end else if (flush_pipeline) begin
          state_nx = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (mem_resp_valid) begin
          state_nx = IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_nx = IDLE;
          wr_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rr_ld          <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_alu        <= '0;
      mem_wdata      <= '0;
      lsu_rdata      <= '0;
      lsu_exu_rvalid <= 1'b0;
      lsu_exu_wready <= 1'b0;
    end else begin
      state          <= state_nx;
      lsu_exu_rvalid <= rv_nx;
      lsu_exu_wready <= wr_nx;
      if (rv_nx) begin
        lsu_rdata <= mem_rdata;
      end
      if (gnt_st) begin
        rr_ld     <= 1'b1;
        mem_wen   <= 1'b1;
        mem_addr  <= exu_waddr;
        mem_alu   <= exu_walu;
        mem_wdata <= exu_wdata;
      end else if (gnt_ld) begin
        rr_ld     <= 1'b0;
        mem_wen   <= 1'b0;
        mem_addr  <= exu_raddr;
        mem_alu   <= exu_ralu;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: doc/lsu_arb.md
LSU_ARB -- requirements
Module: ysyx_lsu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- flush_pipeline  in  1  squash speculative (load) traffic
- exu_ren  in  1  load request
- exu_raddr  in  XLEN  load address
- exu_ralu  in  5  load op code
- exu_wen  in  1  committed store request
- exu_waddr  in  XLEN  store address
- exu_walu  in  5  store strobe code
- exu_wdata  in  XLEN  store data
- lsu_rdata  out  XLEN  load result
- lsu_exu_rvalid  out  1  load done pulse
- lsu_exu_wready  out  1  store done pulse
- mem_valid  out  1  bus request valid
- mem_wen  out  1  1=write, 0=read
- mem_addr  out  XLEN  bus address
- mem_alu  out  5  op/strobe code to bus
- mem_wdata  out  XLEN  bus write data
- mem_ready  in  1  bus accepts request
- mem_resp_valid  in  1  bus response valid
- mem_rdata  in  XLEN  bus read data

Function
REQ-003 SHALL share one memory port between the load and store requesters, with at most one transaction outstanding.
REQ-004 SHALL implement FSM states IDLE, LD_REQ, LD_WAIT, LD_DRAIN, ST_REQ, ST_WAIT.
REQ-005 IDLE: SHALL grant per REQ-006 and latch the winner's address, op and data into internal registers on the grant cycle.
- Store grant -> ST_REQ.
- Load grant -> LD_REQ.
REQ-006 Arbitration, with both requests asserted:
- grant the requester not served last (1-bit round-robin pointer; reset value favours store);
- the pointer SHALL update only on a grant.
REQ-007 Hazard: a load SHALL NOT be granted while exu_wen is high and exu_raddr[XLEN-1:2] equals exu_waddr[XLEN-1:2].
- Store is granted instead, regardless of pointer.
REQ-008 mem_valid SHALL be high only in LD_REQ/ST_REQ.
- mem_addr, mem_alu, mem_wdata and mem_wen SHALL be driven from the latched registers and SHALL stay stable until mem_ready.
REQ-009 LD_REQ & mem_ready -> LD_WAIT; ST_REQ & mem_ready -> ST_WAIT. Request and response SHALL NOT complete in the same cycle.
REQ-010 LD_WAIT & mem_resp_valid -> IDLE.
- One-cycle lsu_exu_rvalid pulse.
- lsu_rdata <= mem_rdata, held until the next load completes.
REQ-011 ST_WAIT & mem_resp_valid -> IDLE with a one-cycle lsu_exu_wready pulse.
REQ-012 Latency: a grant in cycle N gives mem_valid in N+1. With zero-wait mem_ready and a next-cycle response, the done pulse is in N+3.
REQ-013 flush_pipeline:
- In LD_REQ: mem_valid SHALL drop the next cycle -> IDLE.
- In LD_WAIT: -> LD_DRAIN.
- In IDLE: SHALL suppress any load grant that cycle.
REQ-014 LD_DRAIN: SHALL wait for mem_resp_valid, discard the data, assert no lsu_exu_rvalid, then -> IDLE. flush_pipeline in LD_DRAIN SHALL have no effect.
REQ-015 Stores are committed: flush_pipeline SHALL NOT affect ST_REQ/ST_WAIT, and the store SHALL still complete with lsu_exu_wready.
REQ-016 Simultaneous grant and flush SHALL favour a pending store; the pointer SHALL not change on a suppressed load.
REQ-017 mem_resp_valid in IDLE/LD_REQ/ST_REQ SHALL be ignored.
REQ-018 lsu_exu_rvalid and lsu_exu_wready SHALL never be high in the same cycle or for two consecutive cycles.

Reset
REQ-019 While reset=0, asynchronously:
- state=IDLE;
- all outputs 0 (mem_valid, mem_wen, mem_addr, mem_alu, mem_wdata, lsu_rdata, lsu_exu_rvalid, lsu_exu_wready);
- round-robin pointer favours store.
REQ-020 Reset mid-transaction SHALL abandon it without a done pulse. After deassertion, the first grant SHALL occur no earlier than the first clock edge with reset=1.

Verification
REQ-021 Load only: raddr=0x8000_0010, ralu=LW, mem_ready=1, rdata=0xDEAD_BEEF one cycle later -> mem_valid 1 cycle with wen=0, addr 0x8000_0010; rvalid pulse with lsu_rdata=0xDEAD_BEEF at N+3.
REQ-022 Store and load together, no hazard, after reset -> store first (wen=1, wdata driven), wready pulse, then load granted, rvalid pulse; no overlap on the bus.
REQ-023 Hazard: waddr=0x100, raddr=0x102, both asserted with pointer favouring load -> store granted first; load granted only after wready.
REQ-024 Flush in LD_WAIT, response 3 cycles later with 0x1234 -> no rvalid pulse, lsu_rdata unchanged, IDLE after response; a store accepted in the next cycle.
REQ-025 Flush during ST_WAIT -> store completes, wready pulses once.
REQ-026 mem_ready held low 5 cycles in ST_REQ -> mem_valid/addr/wdata stable throughout; reset=0 asserted mid-wait -> all outputs 0 immediately, no done pulse.
